// File: rtl/mdu_pkg.sv
// mdu_pkg -- shared definitions for the multiply/divide unit.
//   md_op_e      : operation encodings carried on md_op (110/111 reserved)
//   mdu_state_e  : sequencing FSM states
//   *_CYCLES_DEF : default busy periods for multiply and divide
//   abs32        : magnitude of a two's-complement 32-bit value
package mdu_pkg;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic [2:0] {
    MD_MULT  = 3'b000,
    MD_MULTU = 3'b001,
    MD_DIV   = 3'b010,
    MD_DIVU  = 3'b011,
    MD_MTHI  = 3'b100,
    MD_MTLO  = 3'b101
  } md_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mdu_state_e;

  // 0x80000000 maps to itself, which is the correct unsigned magnitude.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    logic [31:0] r;
    if (v[31]) begin
      r = 32'd0 - v;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith -- purely combinational arithmetic for the MDU.
//   md_op       : operation select (mdu_pkg::md_op_e encodings)
//   a, b        : operands (rs, rt)
//   hi_res      : product[63:32] or remainder
//   lo_res      : product[31:0] or quotient
//   div_by_zero : high for div/divu with b == 0 (results then meaningless)
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi_res,
  output logic [31:0] lo_res,
  output logic        div_by_zero
);

  logic [63:0] prod_s;
  logic [31:0] a_mag_s;
  logic [31:0] b_mag_s;
  logic [31:0] q_mag_s;
  logic [31:0] r_mag_s;

  // Operation decode and result formation.
  always_comb begin
    prod_s      = 64'd0;
    a_mag_s     = 32'd0;
    b_mag_s     = 32'd0;
    q_mag_s     = 32'd0;
    r_mag_s     = 32'd0;
    hi_res      = 32'd0;
    lo_res      = 32'd0;
    div_by_zero = 1'b0;
    case (md_op)
      MD_MULT: begin
        prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        hi_res = prod_s[63:32];
        lo_res = prod_s[31:0];
      end
      MD_MULTU: begin
        prod_s = {32'd0, a} * {32'd0, b};
        hi_res = prod_s[63:32];
        lo_res = prod_s[31:0];
      end
      MD_DIV: begin
        // Divide magnitudes, then restore signs: quotient negative when the
        // operand signs differ, remainder follows the dividend. The
        // 0x80000000 / -1 overflow falls out as 0x80000000 remainder 0.
        a_mag_s = abs32(a);
        b_mag_s = abs32(b);
        if (b == 32'd0) begin
          div_by_zero = 1'b1;
        end else begin
          q_mag_s = a_mag_s / b_mag_s;
          r_mag_s = a_mag_s % b_mag_s;
          lo_res  = (a[31] ^ b[31]) ? (32'd0 - q_mag_s) : q_mag_s;
          hi_res  = a[31] ? (32'd0 - r_mag_s) : r_mag_s;
        end
      end
      MD_DIVU: begin
        if (b == 32'd0) begin
          div_by_zero = 1'b1;
        end else begin
          lo_res = a / b;
          hi_res = a % b;
        end
      end
      default: begin
        hi_res = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/mdu.sv
// mdu -- multi-cycle multiply/divide unit with HI/LO registers.
//   clk             : clock, rising edge
//   reset           : asynchronous active-low reset
//   start           : issue strobe, accepted only while busy is low
//   md_op           : operation (mdu_pkg::md_op_e; 110/111 are no-ops)
//   rs_data/rt_data : operands, captured at the accepting edge
//   busy            : high for exactly MULT_CYCLES/DIV_CYCLES cycles after a
//                     mul/div accept
//   hi, lo          : registered HI/LO values
// The result is computed at the accept edge and held until the down-counter
// expires, then committed to HI/LO (skipped on divide by zero).
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

  logic [31:0] arith_hi_s;
  logic [31:0] arith_lo_s;
  logic        arith_dbz_s;

  mdu_state_e     state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [31:0]    hi_r, hi_s;
  logic [31:0]    lo_r, lo_s;
  logic [31:0]    res_hi_r, res_hi_s;
  logic [31:0]    res_lo_r, res_lo_s;
  logic           res_dbz_r, res_dbz_s;
  logic           busy_r;

  mdu_arith u_arith (
    .md_op       (md_op),
    .a           (rs_data),
    .b           (rt_data),
    .hi_res      (arith_hi_s),
    .lo_res      (arith_lo_s),
    .div_by_zero (arith_dbz_s)
  );

  // Next-state, counter, capture and HI/LO update logic.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    hi_s      = hi_r;
    lo_s      = lo_r;
    res_hi_s  = res_hi_r;
    res_lo_s  = res_lo_r;
    res_dbz_s = res_dbz_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          case (md_op)
            MD_MULT, MD_MULTU: begin
              state_s   = RUN;
              cnt_s     = MULT_LOAD;
              res_hi_s  = arith_hi_s;
              res_lo_s  = arith_lo_s;
              res_dbz_s = 1'b0;
            end
            MD_DIV, MD_DIVU: begin
              state_s   = RUN;
              cnt_s     = DIV_LOAD;
              res_hi_s  = arith_hi_s;
              res_lo_s  = arith_lo_s;
              res_dbz_s = arith_dbz_s;
            end
            MD_MTHI: begin
              hi_s = rs_data;
            end
            MD_MTLO: begin
              lo_s = rs_data;
            end
            default: begin
              state_s = IDLE;
            end
          endcase
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        // Counter at 1 means this edge takes it to 0: commit and release.
        if (cnt_r <= CNT_ONE) begin
          state_s = IDLE;
          cnt_s   = CNT_ZERO;
          if (!res_dbz_r) begin
            hi_s = res_hi_r;
            lo_s = res_lo_r;
          end else begin
            hi_s = hi_r;
            lo_s = lo_r;
          end
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // State, counter, captured result and HI/LO registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      cnt_r     <= CNT_ZERO;
      hi_r      <= 32'd0;
      lo_r      <= 32'd0;
      res_hi_r  <= 32'd0;
      res_lo_r  <= 32'd0;
      res_dbz_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      hi_r      <= hi_s;
      lo_r      <= lo_s;
      res_hi_r  <= res_hi_s;
      res_lo_r  <= res_lo_s;
      res_dbz_r <= res_dbz_s;
      busy_r    <= (state_s == RUN);
    end
  end

  assign busy = busy_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule

// File: tb/tb_mdu.sv
// tb_mdu -- self-checking bench for mdu: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a
// behavioural model (64-bit integer arithmetic and a busy-cycles-left count).
module tb_mdu;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_errs   = 0;

  mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .md_op   (md_op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference arithmetic using wide signed integers.
  function automatic void ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] h, output logic [31:0] l, output logic ok);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    h = 32'd0; l = 32'd0; ok = 1'b1;
    case (op)
      3'd0: begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
      3'd1: begin p = {32'd0, a} * {32'd0, b}; h = p[63:32]; l = p[31:0]; end
      3'd2: begin
        if (b == 32'd0) ok = 1'b0;
        else begin q = sa / sb; r = sa % sb; l = q[31:0]; h = r[31:0]; end
      end
      3'd3: begin
        if (b == 32'd0) ok = 1'b0;
        else begin l = a / b; h = a % b; end
      end
      default: ok = 1'b0;
    endcase
  endfunction

  // Behavioural model state.
  logic [31:0] m_hi  = 32'd0;
  logic [31:0] m_lo  = 32'd0;
  logic [31:0] m_phi = 32'd0;
  logic [31:0] m_plo = 32'd0;
  logic        m_pok = 1'b0;
  int          m_left = 0;
  logic [31:0] c_h, c_l;
  logic        c_ok;

  always_comb ref_op(md_op, rs_data, rt_data, c_h, c_l, c_ok);

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_hi <= 32'd0; m_lo <= 32'd0; m_phi <= 32'd0; m_plo <= 32'd0;
      m_pok <= 1'b0; m_left <= 0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1 && m_pok) begin
        m_hi <= m_phi;
        m_lo <= m_plo;
      end
    end else if (start) begin
      case (md_op)
        3'd0, 3'd1: begin m_left <= MC; m_phi <= c_h; m_plo <= c_l; m_pok <= c_ok; end
        3'd2, 3'd3: begin m_left <= DC; m_phi <= c_h; m_plo <= c_l; m_pok <= c_ok; end
        3'd4: m_hi <= rs_data;
        3'd5: m_lo <= rs_data;
        default: ;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to the next falling edge and compare the DUT against the model.
  task automatic cycle();
    @(negedge clk);
    chk("model_busy", {31'd0, busy}, {31'd0, (m_left > 0)});
    chk("model_hi", hi, m_hi);
    chk("model_lo", lo, m_lo);
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; md_op = op; rs_data = a; rt_data = b;
    cycle();
    start = 1'b0; md_op = 3'($urandom); rs_data = $urandom; rt_data = $urandom;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 64) begin
      n++;
      cycle();
    end
  endtask

  int          n;
  logic [31:0] th, tl, save_hi, save_lo;
  logic        tok;

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b0; start = 1'b0; md_op = 3'd0; rs_data = 32'd0; rt_data = 32'd0;

    // Pin the model with hand-computed values.
    ref_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, th, tl, tok);
    chk("pin_divovf_lo", tl, 32'h8000_0000);
    chk("pin_divovf_hi", th, 32'h0000_0000);
    ref_op(3'd2, 32'hFFFF_FFF9, 32'd2, th, tl, tok);
    chk("pin_div_lo", tl, 32'hFFFF_FFFD);
    chk("pin_div_hi", th, 32'hFFFF_FFFF);
    ref_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, th, tl, tok);
    chk("pin_multu_hi", th, 32'hFFFF_FFFE);
    chk("pin_multu_lo", tl, 32'h0000_0001);

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    reset = 1'b1;

    // mult / multu.
    issue(3'd0, 32'hFFFF_FFFF, 32'd2);
    wait_idle(n);
    chk("mult_cycles", n, MC);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFE);
    issue(3'd1, 32'hFFFF_FFFF, 32'd2);   // back-to-back with the completion
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    wait_idle(n);
    chk("multu_cycles", n, MC);
    chk("multu_hi", hi, 32'd1);
    chk("multu_lo", lo, 32'hFFFF_FFFE);

    // div / divu.
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    chk("div_cycles", n, DC);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    issue(3'd3, 32'd7, 32'd2);
    wait_idle(n);
    chk("divu_lo", lo, 32'd3);
    chk("divu_hi", hi, 32'd1);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    chk("divovf_lo", lo, 32'h8000_0000);
    chk("divovf_hi", hi, 32'd0);

    // mthi then mtlo on consecutive cycles.
    start = 1'b1; md_op = 3'd4; rs_data = 32'h1234;
    cycle();
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    chk("mthi_hi", hi, 32'h1234);
    md_op = 3'd5; rs_data = 32'h5678;
    cycle();
    start = 1'b0;
    chk("mtlo_busy", {31'd0, busy}, 32'd0);
    chk("mtlo_hi", hi, 32'h1234);
    chk("mtlo_lo", lo, 32'h5678);

    // Start while busy is ignored.
    issue(3'd0, 32'd3, 32'd4);
    cycle();
    start = 1'b1; md_op = 3'd2; rs_data = 32'd100; rt_data = 32'd7;
    cycle();
    start = 1'b0;
    wait_idle(n);
    chk("ignore_cycles", n + 2, MC);
    cycle();
    chk("ignore_busy", {31'd0, busy}, 32'd0);
    chk("ignore_hi", hi, 32'd0);
    chk("ignore_lo", lo, 32'd12);

    // Divide by zero leaves HI/LO untouched.
    issue(3'd4, 32'hA, 32'd0);
    issue(3'd5, 32'hB, 32'd0);
    issue(3'd3, 32'd5, 32'd0);
    wait_idle(n);
    chk("dbz_cycles", n, DC);
    chk("dbz_hi", hi, 32'hA);
    chk("dbz_lo", lo, 32'hB);

    // Reserved opcode is a no-op.
    save_hi = hi; save_lo = lo;
    issue(3'd6, 32'h55, 32'h66);
    chk("rsv_busy", {31'd0, busy}, 32'd0);
    issue(3'd7, 32'h77, 32'h88);
    chk("rsv_hi", hi, save_hi);
    chk("rsv_lo", lo, save_lo);

    // Asynchronous reset in the middle of a divide.
    issue(3'd2, 32'd100, 32'd3);
    cycle();
    #2 reset = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    issue(3'd0, 32'd2, 32'd3);
    wait_idle(n);
    chk("post_rst_cycles", n, MC);
    chk("post_rst_lo", lo, 32'd6);
    chk("post_rst_hi", hi, 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      start   = ($urandom_range(0, 2) == 0);
      md_op   = 3'($urandom);
      rs_data = pick_operand();
      rt_data = pick_operand();
      cycle();
    end
    start = 1'b0;
    repeat (DC + 2) cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 The block SHALL have parameter MULT_CYCLES, default 5, giving busy cycles for mult/multu.
REQ-002 The block SHALL have parameter DIV_CYCLES, default 10, giving busy cycles for div/divu.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset; the ports are listed below.
REQ-004 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port: reset  input  1  asynchronous, active-low reset.
REQ-006 Port: start  input  1  issue strobe, sampled at a clk rising edge.
REQ-007 Port: md_op  input  3  operation: 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo; 110/111 reserved.
REQ-008 Port: rs_data  input  32  first operand (register-file read port 1).
REQ-009 Port: rt_data  input  32  second operand (register-file read port 2).
REQ-010 Port: busy  output  1  high while a multiply or divide is in flight.
REQ-011 Port: hi  output  32  registered HI value.
REQ-012 Port: lo  output  32  registered LO value.

Function
REQ-013 An issue SHALL be accepted only at an edge where start=1 and busy=0; start while busy=1 SHALL be ignored, with no queuing.
REQ-014 rs_data, rt_data and md_op SHALL be captured at the accepting edge; later operand changes SHALL have no effect.
REQ-015 mthi/mtlo SHALL write rs_data into hi/lo at the accepting edge, leave busy low, and leave the other register unchanged.
REQ-016 mult/multu SHALL form the 64-bit product, signed or unsigned; hi gets bits 63:32 and lo gets bits 31:0.
REQ-017 div/divu SHALL place the quotient in lo and the remainder in hi.
REQ-018 Signed div SHALL truncate toward zero, and the remainder SHALL take the sign of the dividend.
REQ-019 Signed div of 0x80000000 by 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0.
REQ-020 Division by zero SHALL run the full DIV_CYCLES busy period and then leave hi/lo unchanged.
REQ-021 FSM states SHALL be IDLE and RUN; a mul/div accept moves IDLE->RUN and loads a down-counter with MULT_CYCLES or DIV_CYCLES.
REQ-022 In RUN the counter SHALL decrement once per cycle; busy=1 throughout RUN.
REQ-023 On the edge where the counter reaches 0, the FSM SHALL commit hi/lo and return to IDLE, so busy is high for exactly N cycles after the accept edge.
REQ-024 The result SHALL be visible on hi/lo in the cycle in which busy first reads 0.
REQ-025 A new start SHALL be accepted in that same cycle, back-to-back with the previous completion.
REQ-026 Reserved md_op values SHALL be accepted as no-ops: no state change and busy stays low.
REQ-027 hi/lo SHALL change only on a commit, an mthi/mtlo, or reset.

Reset
REQ-028 While reset=0: hi=0, lo=0, busy=0, FSM=IDLE, counter=0, captured result=0.
REQ-029 Reset asserted mid-operation SHALL discard the pending result immediately, without waiting for a clock edge.
REQ-030 After reset deasserts, the first clk edge with start=1 SHALL be accepted.

Structure
REQ-031 A shared package mdu_pkg SHALL hold the md_op encodings, the FSM state typedef, and the MULT_CYCLES/DIV_CYCLES defaults.
REQ-032 Arithmetic SHALL live in one combinational sub-module, mdu_arith, mapping (md_op, a, b) to {hi_res, lo_res, div_by_zero}.
REQ-033 mdu SHALL register the mdu_arith outputs at accept, and hold the FSM, counter and HI/LO registers.

Verification
REQ-034 Scenario: mult with rs=0xFFFFFFFF, rt=2 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE; multu with the same operands -> hi=1, lo=0xFFFFFFFE.
REQ-035 Scenario: div with rs=-7, rt=2 -> busy high 10 cycles, then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); divu 7/2 -> lo=3, hi=1.
REQ-036 Scenario: mthi 0x1234 then mtlo 0x5678 on consecutive cycles -> hi=0x1234, lo=0x5678, busy never asserted.
REQ-037 Scenario: start mult 3*4, then start div on cycle 2 of RUN -> div ignored, final hi=0, lo=12.
REQ-038 Scenario: divu rs=5, rt=0 with prior hi=0xA, lo=0xB -> busy 10 cycles, then hi=0xA, lo=0xB.
REQ-039 Scenario: reset pulled low at cycle 3 of a div -> busy=0 and hi=lo=0 immediately; a following mult 2*3 yields lo=6 after 5 cycles.
